// File: rtl/pla_bench_pkg.sv
// pla_bench_pkg: shared sweep state, signature type and default MISR polynomial
package pla_bench_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sweep_state_t;
  typedef logic [31:0] sig_t;
  localparam sig_t SIG_POLY_DEFAULT = 32'h04C11DB7;
endpackage

// File: rtl/pla_sweep_sequencer_if.sv
// pla_sweep_sequencer_if: host control, FUT drive/response and result signals of the sweep sequencer
interface pla_sweep_sequencer_if
  import pla_bench_pkg::*;
#(
  parameter int N_IN = 22
);
  logic start;
  logic abort;
  logic [N_IN-1:0] range_lo;
  logic [N_IN-1:0] range_hi;
  logic [N_IN-1:0] vec_out;
  logic vec_valid;
  logic f_in;
  logic busy;
  logic done;
  logic range_err;
  logic [N_IN:0] onset_cnt;
  logic [N_IN-1:0] first_onset;
  logic first_valid;
  sig_t sig;
  modport slave (
    input start, abort, range_lo, range_hi, f_in,
    output vec_out, vec_valid, busy, done, range_err, onset_cnt, first_onset, first_valid, sig
  );
  modport master (
    output start, abort, range_lo, range_hi, f_in,
    input vec_out, vec_valid, busy, done, range_err, onset_cnt, first_onset, first_valid, sig
  );
endinterface

// File: rtl/pla_misr.sv
// pla_misr: 32-bit serial-input MISR with synchronous clear and enable
module pla_misr
  import pla_bench_pkg::*;
#(
  parameter sig_t POLY = SIG_POLY_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic din,
  output sig_t sig
);
  always_ff @(posedge clk)
    if (rst || clr) sig <= '0;
    else if (en) sig <= {sig[30:0], 1'b0} ^ (sig[31] ? POLY : '0) ^ {31'b0, din};
endmodule

// File: rtl/pla_sweep_sequencer.sv
// pla_sweep_sequencer: sweeps a minterm range through a FUT and compacts its responses
module pla_sweep_sequencer
  import pla_bench_pkg::*;
#(
  parameter int   N_IN     = 22,
  parameter int   FUT_LAT  = 0,
  parameter sig_t SIG_POLY = SIG_POLY_DEFAULT
) (
  input logic clk,
  input logic rst,
  pla_sweep_sequencer_if.slave bus
);
  sweep_state_t state, state_n;
  logic [N_IN-1:0] vec, hi_q, dvec, first_onset;
  logic [N_IN:0] onset_cnt;
  logic [7:0] dcnt;
  logic vv, dv, acc, last, go, range_err, first_valid;
  sig_t sig;
  assign vv = state == RUN;
  assign last = vec == hi_q;
  assign go = state == IDLE && bus.start;
  assign acc = dv && (state == RUN || state == DRAIN);
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !bus.start ? IDLE : bus.range_lo > bus.range_hi ? DONE : RUN;
      RUN:     state_n = bus.abort ? IDLE : !last ? RUN : FUT_LAT == 0 ? DONE : DRAIN;
      DRAIN:   state_n = bus.abort ? IDLE : dcnt == 8'd0 ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  // response alignment: valid/vector travel alongside the FUT pipeline
  if (FUT_LAT == 0) begin : g_comb
    assign dv = vv;
    assign dvec = vec;
  end else begin : g_pipe
    logic [FUT_LAT-1:0] v_sr;
    logic [N_IN-1:0] d_sr [FUT_LAT];
    always_ff @(posedge clk) begin
      if (rst || state == IDLE) v_sr <= '0;
      else begin
        v_sr[0] <= vv;
        for (int i = 1; i < FUT_LAT; i++) v_sr[i] <= v_sr[i-1];
      end
    end
    always_ff @(posedge clk) begin
      d_sr[0] <= vec;
      for (int i = 1; i < FUT_LAT; i++) d_sr[i] <= d_sr[i-1];
    end
    assign dv = v_sr[FUT_LAT-1];
    assign dvec = d_sr[FUT_LAT-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vec <= '0;
      hi_q <= '0;
      dcnt <= '0;
      range_err <= 1'b0;
      onset_cnt <= '0;
      first_onset <= '0;
      first_valid <= 1'b0;
    end else begin
      dcnt <= state == RUN ? 8'(FUT_LAT - 1) : state == DRAIN ? dcnt - 8'd1 : dcnt;
      if (go) begin
        vec <= bus.range_lo;
        hi_q <= bus.range_hi;
        range_err <= bus.range_lo > bus.range_hi;
        onset_cnt <= '0;
        first_onset <= '0;
        first_valid <= 1'b0;
      end else begin
        if (vv && !last && !bus.abort) vec <= vec + 1'b1;
        if (acc) onset_cnt <= onset_cnt + {{N_IN{1'b0}}, bus.f_in};
        if (acc && bus.f_in && !first_valid) begin
          first_onset <= dvec;
          first_valid <= 1'b1;
        end
      end
    end
  end
  pla_misr #(.POLY(SIG_POLY)) u_misr (
    .clk(clk), .rst(rst), .clr(go), .en(acc), .din(bus.f_in), .sig(sig)
  );
  assign bus.vec_out = vec;
  assign bus.vec_valid = vv;
  assign bus.busy = state == RUN || state == DRAIN;
  assign bus.done = state == DONE;
  assign bus.range_err = range_err;
  assign bus.onset_cnt = onset_cnt;
  assign bus.first_onset = first_onset;
  assign bus.first_valid = first_valid;
  assign bus.sig = sig;
endmodule

// File: tb/tb_pla_sweep_sequencer.sv
// tb_pla_sweep_sequencer: directed vector table plus abort, reset-in-drain and wide-range sequences
module tb_pla_sweep_sequencer;
  import pla_bench_pkg::*;
  logic clk = 1'b0;
  logic rst, start, abort, fsel, start22;
  logic [3:0] lo, hi;
  logic [21:0] lo22, hi22;
  logic [2:0] p3 = 3'b0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  pla_sweep_sequencer_if #(.N_IN(4)) b0 ();
  pla_sweep_sequencer_if #(.N_IN(4)) b3 ();
  pla_sweep_sequencer_if #(.N_IN(22)) b22 ();
  assign b0.start = start;
  assign b0.abort = abort;
  assign b0.range_lo = lo;
  assign b0.range_hi = hi;
  assign b3.start = start;
  assign b3.abort = abort;
  assign b3.range_lo = lo;
  assign b3.range_hi = hi;
  assign b22.start = start22;
  assign b22.abort = 1'b0;
  assign b22.range_lo = lo22;
  assign b22.range_hi = hi22;
  // FUT models: fsel=1 is constant 1, otherwise x0 & x1
  assign b0.f_in = fsel | (b0.vec_out[0] & b0.vec_out[1]);
  always @(posedge clk) p3 <= {p3[1:0], fsel | (b3.vec_out[0] & b3.vec_out[1])};
  assign b3.f_in = p3[2];
  assign b22.f_in = 1'b1;
  pla_sweep_sequencer #(.N_IN(4), .FUT_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  pla_sweep_sequencer #(.N_IN(4), .FUT_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  pla_sweep_sequencer #(.N_IN(22), .FUT_LAT(0)) dut22 (.clk(clk), .rst(rst), .bus(b22));

  typedef struct {
    logic [3:0] lo, hi;
    bit f1;
    int cnt;
    logic [3:0] first;
    bit fv, err;
  } vec_t;
  vec_t tv [6];

  function automatic sig_t ref_sig(input int l, input int h, input bit f1);
    sig_t s = '0;
    bit b;
    for (int m = l; m <= h; m++) begin
      b = f1 | (m[0] & m[1]);
      s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ {31'b0, b};
    end
    return s;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t t);
    int c0, c3, v0, v3, dr, n;
    sig_t es;
    n = t.err ? 0 : int'(t.hi) - int'(t.lo) + 1;
    es = ref_sig(t.lo, t.hi, t.f1);
    fsel = t.f1;
    @(negedge clk);
    lo = t.lo;
    hi = t.hi;
    start = 1'b1;
    c0 = -1; c3 = -1; v0 = 0; v3 = 0; dr = 0;
    for (int k = 1; k <= 60 && (c0 < 0 || c3 < 0); k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      v0 += int'(b0.vec_valid);
      v3 += int'(b3.vec_valid);
      if (b3.busy && !b3.vec_valid) dr++;
      if (b0.done && c0 < 0) c0 = k;
      if (b3.done && c3 < 0) c3 = k;
    end
    chk($sformatf("v%0d done_cycle_lat0", idx), c0, t.err ? 1 : n + 1);
    chk($sformatf("v%0d done_cycle_lat3", idx), c3, t.err ? 1 : n + 4);
    chk($sformatf("v%0d vectors_lat0", idx), v0, n);
    chk($sformatf("v%0d vectors_lat3", idx), v3, n);
    chk($sformatf("v%0d drain_cycles", idx), dr, t.err ? 0 : 3);
    chk($sformatf("v%0d onset_lat0", idx), b0.onset_cnt, t.cnt);
    chk($sformatf("v%0d onset_lat3", idx), b3.onset_cnt, t.cnt);
    chk($sformatf("v%0d first_lat0", idx), {b0.first_valid, b0.first_onset}, {t.fv, t.first});
    chk($sformatf("v%0d first_lat3", idx), {b3.first_valid, b3.first_onset}, {t.fv, t.first});
    chk($sformatf("v%0d range_err", idx), {b0.range_err, b3.range_err}, {t.err, t.err});
    chk($sformatf("v%0d sig_lat0", idx), b0.sig, es);
    chk($sformatf("v%0d sig_lat3", idx), b3.sig, es);
    if (!t.err) chk($sformatf("v%0d last_vec", idx), b0.vec_out, t.hi);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d post_done", idx), {b0.done, b0.busy, b3.done, b3.busy}, 4'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    int c, v;
    tv[0] = '{lo: 4'd0,  hi: 4'd15, f1: 1'b0, cnt: 4, first: 4'd3,  fv: 1'b1, err: 1'b0};
    tv[1] = '{lo: 4'd4,  hi: 4'd9,  f1: 1'b0, cnt: 1, first: 4'd7,  fv: 1'b1, err: 1'b0};
    tv[2] = '{lo: 4'd9,  hi: 4'd4,  f1: 1'b0, cnt: 0, first: 4'd0,  fv: 1'b0, err: 1'b1};
    tv[3] = '{lo: 4'd15, hi: 4'd15, f1: 1'b1, cnt: 1, first: 4'd15, fv: 1'b1, err: 1'b0};
    tv[4] = '{lo: 4'd0,  hi: 4'd3,  f1: 1'b1, cnt: 4, first: 4'd0,  fv: 1'b1, err: 1'b0};
    tv[5] = '{lo: 4'd8,  hi: 4'd10, f1: 1'b0, cnt: 0, first: 4'd0,  fv: 1'b0, err: 1'b0};
    rst = 1'b1; start = 1'b0; abort = 1'b0; fsel = 1'b0; lo = '0; hi = '0;
    start22 = 1'b0; lo22 = '0; hi22 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ctl", {b0.busy, b0.done, b0.vec_valid, b0.range_err, b0.first_valid}, 5'b0);
    chk("reset onset", b0.onset_cnt, 0);
    chk("reset sig", b0.sig, 0);
    chk("reset vec", {b0.vec_out, b0.first_onset}, 0);
    chk("reset lat3", {b3.busy, b3.done, b3.vec_valid, b3.onset_cnt, b3.sig}, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) apply(i, tv[i]);

    // abort on the 5th RUN cycle with a start pulse mid-run that must be ignored
    fsel = 1'b1;
    @(negedge clk);
    lo = 4'd0; hi = 4'd15; start = 1'b1;
    v = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      start = k == 3;
      abort = k == 5;
      v += int'(b0.vec_valid);
    end
    chk("abort idle", {b0.busy, b0.vec_valid, b3.busy, b3.vec_valid}, 4'b0);
    chk("abort vectors", v, 5);
    chk("abort onset_lat0", b0.onset_cnt, 5);
    chk("abort onset_lat3", b3.onset_cnt, 2);
    chk("abort sig_lat0", b0.sig, ref_sig(0, 4, 1'b1));
    chk("abort sig_lat3", b3.sig, ref_sig(0, 1, 1'b1));
    chk("abort first", {b0.first_valid, b0.first_onset}, 5'b10000);
    c = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      c += int'(b0.done) + int'(b3.done) + int'(b0.busy) + int'(b3.busy);
    end
    chk("abort no_done", c, 0);
    chk("abort frozen", b0.onset_cnt, 5);

    // reset while the latency-3 instance is draining
    fsel = 1'b0;
    @(negedge clk);
    lo = 4'd0; hi = 4'd15; start = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("in drain", {b3.busy, b3.vec_valid}, 2'b10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst drain ctl", {b3.busy, b3.done, b3.vec_valid, b3.first_valid, b3.range_err}, 5'b0);
    chk("rst drain data", {b3.onset_cnt, b3.first_onset, b3.vec_out}, 0);
    chk("rst drain sig", {b3.sig, b0.sig}, 64'h0);
    rst = 1'b0;
    apply(10, tv[0]);

    // single all-ones vector on the wide instance must not wrap
    @(negedge clk);
    lo22 = 22'h3FFFFF; hi22 = 22'h3FFFFF; start22 = 1'b1;
    c = -1; v = 0;
    for (int k = 1; k <= 10 && c < 0; k++) begin
      @(posedge clk);
      #1;
      start22 = 1'b0;
      v += int'(b22.vec_valid);
      if (b22.done) c = k;
    end
    chk("n22 done_cycle", c, 2);
    chk("n22 vectors", v, 1);
    chk("n22 onset", b22.onset_cnt, 1);
    chk("n22 first", {b22.first_valid, b22.first_onset}, 23'h7FFFFF);
    chk("n22 vec_hold", b22.vec_out, 22'h3FFFFF);
    chk("n22 sig", b22.sig, 32'h1);
    chk("n22 err", b22.range_err, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
